// File: rtl/booth_pkg.sv
// Shared radix-4 Booth definitions: action bit positions, FSM states and the triplet recoder.
// Used by booth_pp_accumulator (optional addend via BOOTH_MAC_ADDEND_EN) and booth_pp_row.
package booth_pkg;

  localparam int ACT_SGL = 0;
  localparam int ACT_DBL = 1;
  localparam int ACT_NEG = 2;

  typedef logic [2:0] booth_act_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  // Triplet is {b[2g+1], b[2g], b[2g-1]}; a negative action always carries a magnitude bit.
  function automatic booth_act_t booth_recode(input logic [2:0] trip);
    booth_act_t act;
    act = '0;
    case (trip)
      3'b001, 3'b010: act[ACT_SGL] = 1'b1;
      3'b011:         act[ACT_DBL] = 1'b1;
      3'b100: begin
        act[ACT_NEG] = 1'b1;
        act[ACT_DBL] = 1'b1;
      end
      3'b101, 3'b110: begin
        act[ACT_NEG] = 1'b1;
        act[ACT_SGL] = 1'b1;
      end
      default:        act = '0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// Combinational (W+1)-bit Booth partial-product row: selects a or 2a, inverts when negative.
// The +1 that completes the negation is added by the accumulator as a carry-in.
module booth_pp_row
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  booth_act_t   act_i,
  output logic [W:0]   row_o
);

  logic [W:0] a_ext;
  logic [W:0] mag;

  assign a_ext = {a_i[W-1], a_i};

  // W+1 bits hold 2a exactly, so doubling is a plain one-bit left shift of the extended operand.
  generate
    for (genvar gi = 0; gi <= W; gi++) begin : g_mag
      if (gi == 0) begin : g_lsb
        assign mag[gi] = act_i[ACT_SGL] & a_ext[gi];
      end else begin : g_bit
        assign mag[gi] = (act_i[ACT_SGL] & a_ext[gi]) | (act_i[ACT_DBL] & a_ext[gi-1]);
      end
    end
  endgenerate

  assign row_o = mag ^ {(W+1){act_i[ACT_NEG]}};

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth multiplier, one group per cycle, valid/ready on both sides.
// Define BOOTH_MAC_ADDEND_EN to add port c and preload the accumulator with it (p = a*b + c).
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
`ifdef BOOTH_MAC_ADDEND_EN
  input  logic signed [2*W-1:0] c,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] p
);

  localparam int GW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [GW-1:0] LAST_G = GW'(W / 2 - 1);

  booth_state_t   state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [GW-1:0]  g_q, g_d;
  logic [2*W-1:0] acc_q, acc_d;

  logic [2*W-1:0] acc_init;
  logic [W:0]     b_ext;
  logic [2:0]     trip;
  booth_act_t     act;
  logic [W:0]     row;
  logic [2*W-1:0] row_ext;
  logic [2*W-1:0] row_shift;
  logic [2*W-1:0] carry_shift;
  logic [GW:0]    shamt;

`ifdef BOOTH_MAC_ADDEND_EN
  assign acc_init = c;
`else
  assign acc_init = '0;
`endif

  // b[-1] is the implicit zero below the multiplier LSB.
  assign b_ext = {b_q, 1'b0};
  assign shamt = {g_q, 1'b0};
  assign trip  = b_ext[shamt +: 3];
  assign act   = booth_recode(trip);

  booth_pp_row #(
    .W (W)
  ) u_row (
    .a_i   (a_q),
    .act_i (act),
    .row_o (row)
  );

  assign row_ext     = {{(W-1){row[W]}}, row};
  assign row_shift   = row_ext << shamt;
  assign carry_shift = {{(2*W-1){1'b0}}, act[ACT_NEG]} << shamt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          g_d     = '0;
          acc_d   = acc_init;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + row_shift + carry_shift;
        if (g_q == LAST_G) begin
          state_d = DONE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = acc_q;

endmodule
